// File: rtl/mem_access_pkg.sv
// Shared definitions for the MIPS data-memory access stage: op codes,
// FSM state encoding, the default ack timeout and small decode helpers.
package mips_mem_pkg;

    localparam int ACK_TIMEOUT_DEFAULT = 15;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Codes 9..15 fall outside this range and behave as NONE.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // True when the low address bits do not match the access size.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        return (is_half(op) && lo[0]) || (is_word(op) && (lo != 2'b00));
    endfunction

    // Clears the low address bits that the access size does not allow.
    function automatic logic [1:0] force_align(input logic [3:0] op, input logic [1:0] lo);
        logic [1:0] res;
        res = lo;
        if (is_half(op)) begin
            res = {lo[1], 1'b0};
        end else if (is_word(op)) begin
            res = 2'b00;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-RAM port: request/ack handshake plus address, strobes and data.
// The access stage drives it through the master modport, the RAM through slave.
interface mem_access_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wstrb,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ack
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wstrb,
        input  dm_wdata,
        output dm_rdata,
        output dm_ack
    );
endinterface

// File: rtl/mem_access_align.sv
// Combinational lane logic for the access stage: store data replication and
// byte strobes, and load byte/halfword extraction with sign/zero extension.
module mem_align
    import mips_mem_pkg::*;
(
    input  logic [3:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [3:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store steering: replicate the datum across lanes and enable only its lanes.
    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        case (st_op)
            OP_SB: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_off;
            end
            OP_SH: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = st_off[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
            default: begin
                st_wdata = '0;
                st_wstrb = '0;
            end
        endcase
    end

    // Load extraction: pick the addressed lane(s) and extend to 32 bits.
    always_comb begin
        ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
        ld_data = '0;
        case (ld_op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h000000, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0000, ld_half};
            OP_LW:   ld_data = ld_rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MIPS data-memory access stage. Issues one word-aligned RAM request per
// EX/MEM load/store, stalls the pipeline until ack (or timeout), and
// registers the extended load result on ram_out.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// accesses raise mem_adel/mem_ades and are not issued; when undefined the
// offending low address bits are cleared and the access proceeds.
module mem_access
    import mips_mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ex_valid,
    input  logic [3:0]         ex_mem_op,
    input  logic [31:0]        ex_alu_out,
    input  logic [31:0]        ex_rdata2,
    mem_access_if.master       dm,
    output logic [31:0]        ram_out,
    output logic               mem_stall,
    output logic               mem_adel,
    output logic               mem_ades,
    output logic               mem_bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_e      state;
    state_e      next_state;
    logic [7:0]  wait_cnt;
    logic        mem_op;
    logic        misaligned;
    logic        issue;
    logic [1:0]  eff_off;
    logic        capture;
    logic        timeout;

    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    assign mem_op = ex_valid && is_mem_op(ex_mem_op);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = mem_op && is_misaligned(ex_mem_op, ex_alu_out[1:0]);
    assign eff_off    = ex_alu_out[1:0];
`else
    assign misaligned = 1'b0;
    assign eff_off    = force_align(ex_mem_op, ex_alu_out[1:0]);
`endif

    assign issue = mem_op && !misaligned;

    mem_align u_align (
        .st_op    (ex_mem_op),
        .st_off   (eff_off),
        .st_data  (ex_rdata2),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_op    (op_q),
        .ld_off   (off_q),
        .ld_rdata (dm.dm_rdata),
        .ld_data  (ld_data)
    );

    // Next-state decode, load capture / timeout strobes and the stall output.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dm.dm_ack) begin
                    next_state = ST_DONE;
                    capture    = !is_store(op_q);
                end else if (wait_cnt == CNT_LAST) begin
                    next_state = ST_DONE;
                    timeout    = 1'b1;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        mem_stall = resetn && (((state == ST_IDLE) && issue) || (state == ST_WAIT));
    end

    assign dm.dm_req   = (state == ST_WAIT);
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wstrb = wstrb_q;
    assign dm.dm_wdata = wdata_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ack timeout counter: cleared on entry to WAIT, counts ack-less WAIT cycles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if ((state == ST_IDLE) && issue) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && !dm.dm_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Request registers: latched at issue so the bus stays stable through WAIT.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q    <= OP_NONE;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if ((state == ST_IDLE) && issue) begin
            op_q    <= ex_mem_op;
            off_q   <= eff_off;
            we_q    <= is_store(ex_mem_op);
            addr_q  <= {ex_alu_out[31:2], 2'b00};
            wstrb_q <= st_wstrb;
            wdata_q <= st_wdata;
        end
    end

    // Load result register: updated only when a load is acked.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ram_out <= '0;
        end else if (capture) begin
            ram_out <= ld_data;
        end
    end

    // Single-cycle exception pulses for misalignment and bus timeout.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_adel    <= 1'b0;
            mem_ades    <= 1'b0;
            mem_bus_err <= 1'b0;
        end else begin
            mem_adel    <= (state == ST_IDLE) && misaligned && !is_store(ex_mem_op);
            mem_ades    <= (state == ST_IDLE) && misaligned && is_store(ex_mem_op);
            mem_bus_err <= timeout;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: a table of single accesses with
// hand-computed bus and load results, plus sequences for timeout,
// ack-at-limit, non-memory ops, misalignment and reset during WAIT.
module tb_mem_access;
    import mips_mem_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          ackDelay;
        logic [31:0] expAddr;
        logic        expWe;
        logic [3:0]  expWstrb;
        logic [31:0] expWdata;
        logic        chkWdata;
        logic [31:0] expRam;
        int          expStall;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        ex_valid;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rdata2;
    logic [31:0] ram_out;
    logic        mem_stall;
    logic        mem_adel;
    logic        mem_ades;
    logic        mem_bus_err;

    mem_access_if bus ();

    mem_access dut (
        .clk         (clk),
        .resetn      (resetn),
        .ex_valid    (ex_valid),
        .ex_mem_op   (ex_mem_op),
        .ex_alu_out  (ex_alu_out),
        .ex_rdata2   (ex_rdata2),
        .dm          (bus.master),
        .ram_out     (ram_out),
        .mem_stall   (mem_stall),
        .mem_adel    (mem_adel),
        .mem_ades    (mem_ades),
        .mem_bus_err (mem_bus_err)
    );

    int passCount;
    int totalCount;

    int          stallCount;
    int          busErrCount;
    logic        sawReq;
    logic        ended;
    logic        stableOk;
    logic [31:0] capAddr;
    logic        capWe;
    logic [3:0]  capWstrb;
    logic [31:0] capWdata;
    logic [31:0] ramDone;
    logic        adelFirst;
    logic        adesFirst;
    logic        reqAfter;
    logic        busErrAfter;
    logic        adelAfter;
    logic        adesAfter;
    logic [31:0] expRam;

    vec_t vecs[10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one instruction from IDLE and play the RAM side; ackDelay < 0
    // never acks. Leaves the FSM back in IDLE one cycle after DONE.
    task automatic runAccess(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] rt, input logic [31:0] rdata,
                             input int ackDelay, input int maxCycles);
        int waitIdx;
        stallCount  = 0;
        busErrCount = 0;
        sawReq      = 1'b0;
        ended       = 1'b0;
        stableOk    = 1'b1;
        ramDone     = '0;
        waitIdx     = 0;
        ex_valid    = 1'b1;
        ex_mem_op   = op;
        ex_alu_out  = addr;
        ex_rdata2   = rt;
        bus.dm_ack  = 1'b0;
        #1;
        if (mem_stall) stallCount++;
        for (int c = 0; c < maxCycles && !ended; c++) begin
            tick();
            bus.dm_ack = 1'b0;
            if (c == 0) begin
                adelFirst = mem_adel;
                adesFirst = mem_ades;
            end
            if (mem_bus_err) busErrCount++;
            if (bus.dm_req) begin
                if (!sawReq) begin
                    capAddr  = bus.dm_addr;
                    capWe    = bus.dm_we;
                    capWstrb = bus.dm_wstrb;
                    capWdata = bus.dm_wdata;
                end else if ((bus.dm_addr !== capAddr) || (bus.dm_we !== capWe) ||
                             (bus.dm_wstrb !== capWstrb) || (bus.dm_wdata !== capWdata)) begin
                    stableOk = 1'b0;
                end
                sawReq = 1'b1;
                if (mem_stall) stallCount++;
                if (waitIdx == ackDelay) begin
                    bus.dm_ack   = 1'b1;
                    bus.dm_rdata = rdata;
                end
                waitIdx++;
            end else begin
                ramDone   = ram_out;
                ended     = 1'b1;
                ex_valid  = 1'b0;
                ex_mem_op = OP_NONE;
            end
        end
        if (!ended) begin
            checkOutput("access_cycle_budget", 32'd0, 32'd1);
            ex_valid  = 1'b0;
            ex_mem_op = OP_NONE;
        end
        tick();
        reqAfter    = bus.dm_req;
        busErrAfter = mem_bus_err;
        adelAfter   = mem_adel;
        adesAfter   = mem_ades;
    endtask

    task automatic applyStimulus(input vec_t v);
        runAccess(v.op, v.addr, v.rt, v.rdata, v.ackDelay, 40);
    endtask

    initial begin
        passCount    = 0;
        totalCount   = 0;
        resetn       = 1'b0;
        ex_valid     = 1'b0;
        ex_mem_op    = OP_NONE;
        ex_alu_out   = '0;
        ex_rdata2    = '0;
        bus.dm_rdata = '0;
        bus.dm_ack   = 1'b0;

        vecs[0] = '{OP_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'h0000_0100, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 2};
        vecs[1] = '{OP_LB,  32'h0000_0103, 32'h0000_0000, 32'h80FF_0000, 0, 32'h0000_0100, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 32'hFFFF_FF80, 2};
        vecs[2] = '{OP_LBU, 32'h0000_0103, 32'h0000_0000, 32'h80FF_0000, 0, 32'h0000_0100, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 32'h0000_0080, 2};
        vecs[3] = '{OP_SH,  32'h0000_0202, 32'h1234_ABCD, 32'h0000_0000, 0, 32'h0000_0200, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0000_0080, 2};
        vecs[4] = '{OP_LH,  32'h0000_0202, 32'h0000_0000, 32'hABCD_0000, 0, 32'h0000_0200, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 32'hFFFF_ABCD, 2};
        vecs[5] = '{OP_LW,  32'h0000_0300, 32'h0000_0000, 32'h1234_5678, 3, 32'h0000_0300, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 32'h1234_5678, 5};
        vecs[6] = '{OP_LHU, 32'h0000_0400, 32'h0000_0000, 32'h1234_F00D, 1, 32'h0000_0400, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 32'h0000_F00D, 3};
        vecs[7] = '{OP_SB,  32'h0000_0401, 32'h0000_00A5, 32'h0000_0000, 0, 32'h0000_0400, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0000_F00D, 2};
        vecs[8] = '{OP_LB,  32'h0000_0401, 32'h0000_0000, 32'h0000_7F00, 2, 32'h0000_0400, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 32'h0000_007F, 4};
        vecs[9] = '{OP_SH,  32'h0000_0500, 32'hCAFE_1234, 32'h0000_0000, 0, 32'h0000_0500, 1'b1, 4'b0011, 32'h1234_1234, 1'b1, 32'h0000_007F, 2};

        // Reset state.
        tick();
        tick();
        checkOutput("rst_dm_req",      {31'd0, bus.dm_req},   32'd0);
        checkOutput("rst_dm_we",       {31'd0, bus.dm_we},    32'd0);
        checkOutput("rst_dm_addr",     bus.dm_addr,           32'd0);
        checkOutput("rst_dm_wstrb",    {28'd0, bus.dm_wstrb}, 32'd0);
        checkOutput("rst_dm_wdata",    bus.dm_wdata,          32'd0);
        checkOutput("rst_ram_out",     ram_out,               32'd0);
        checkOutput("rst_mem_stall",   {31'd0, mem_stall},    32'd0);
        checkOutput("rst_mem_adel",    {31'd0, mem_adel},     32'd0);
        checkOutput("rst_mem_ades",    {31'd0, mem_ades},     32'd0);
        checkOutput("rst_mem_bus_err", {31'd0, mem_bus_err},  32'd0);
        checkOutput("rst_state",       {30'd0, dut.state},    {30'd0, ST_IDLE});
        resetn = 1'b1;
        tick();

        // Table-driven single accesses.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_stall_cycles", i), stallCount, vecs[i].expStall);
            checkOutput($sformatf("v%0d_dm_addr", i), capAddr, vecs[i].expAddr);
            checkOutput($sformatf("v%0d_dm_we", i), {31'd0, capWe}, {31'd0, vecs[i].expWe});
            checkOutput($sformatf("v%0d_dm_wstrb", i), {28'd0, capWstrb}, {28'd0, vecs[i].expWstrb});
            if (vecs[i].chkWdata) begin
                checkOutput($sformatf("v%0d_dm_wdata", i), capWdata, vecs[i].expWdata);
            end
            checkOutput($sformatf("v%0d_bus_stable", i), {31'd0, stableOk}, 32'd1);
            checkOutput($sformatf("v%0d_ram_out_done", i), ramDone, vecs[i].expRam);
            checkOutput($sformatf("v%0d_ram_out_hold", i), ram_out, vecs[i].expRam);
            checkOutput($sformatf("v%0d_req_after", i), {31'd0, reqAfter}, 32'd0);
            checkOutput($sformatf("v%0d_bus_err", i), busErrCount, 0);
            expRam = vecs[i].expRam;
        end

        // No ack at all: 15 WAIT cycles, one bus error pulse, ram_out kept.
        runAccess(OP_LW, 32'h0000_0600, 32'h0, 32'hFFFF_FFFF, -1, 40);
        checkOutput("to_stall_cycles",  stallCount,  16);
        checkOutput("to_bus_err_count", busErrCount, 1);
        checkOutput("to_bus_err_after", {31'd0, busErrAfter}, 32'd0);
        checkOutput("to_ram_out",       ramDone,     expRam);
        checkOutput("to_req_after",     {31'd0, reqAfter}, 32'd0);
        checkOutput("to_state_idle",    {30'd0, dut.state}, {30'd0, ST_IDLE});

        // Ack in the same cycle the counter expires: ack wins.
        runAccess(OP_LW, 32'h0000_0604, 32'h0, 32'h0BAD_F00D, 14, 40);
        checkOutput("atl_stall_cycles", stallCount,  16);
        checkOutput("atl_bus_err",      busErrCount, 0);
        checkOutput("atl_ram_out",      ramDone,     32'h0BAD_F00D);
        expRam = 32'h0BAD_F00D;

        // Non-memory ops and stray ack: no stall, no request, ram_out kept.
        ex_valid     = 1'b1;
        ex_mem_op    = OP_NONE;
        ex_alu_out   = 32'h0000_0700;
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'h5555_5555;
        #1;
        checkOutput("none_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        checkOutput("none_req",     {31'd0, bus.dm_req}, 32'd0);
        checkOutput("none_ram_out", ram_out, expRam);
        ex_mem_op = 4'd9;
        #1;
        checkOutput("op9_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        checkOutput("op9_req", {31'd0, bus.dm_req}, 32'd0);
        ex_valid  = 1'b0;
        ex_mem_op = OP_LW;
        #1;
        checkOutput("invalid_lw_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        checkOutput("invalid_lw_req",     {31'd0, bus.dm_req}, 32'd0);
        checkOutput("stray_ack_ram_out",  ram_out, expRam);
        bus.dm_ack = 1'b0;
        ex_mem_op  = OP_NONE;
        tick();

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned load/store trap instead of issuing.
        runAccess(OP_LW, 32'h0000_0101, 32'h0, 32'h1122_3344, 0, 40);
        checkOutput("adel_stall",   stallCount, 0);
        checkOutput("adel_no_req",  {31'd0, sawReq}, 32'd0);
        checkOutput("adel_pulse",   {31'd0, adelFirst}, 32'd1);
        checkOutput("adel_after",   {31'd0, adelAfter}, 32'd0);
        checkOutput("adel_ram_out", ram_out, expRam);
        runAccess(OP_SW, 32'h0000_0102, 32'hA5A5_0F0F, 32'h0, 0, 40);
        checkOutput("ades_stall",   stallCount, 0);
        checkOutput("ades_no_req",  {31'd0, sawReq}, 32'd0);
        checkOutput("ades_pulse",   {31'd0, adesFirst}, 32'd1);
        checkOutput("ades_adel",    {31'd0, adelFirst}, 32'd0);
        checkOutput("ades_after",   {31'd0, adesAfter}, 32'd0);
`else
        // Misaligned accesses are forced aligned and complete normally.
        runAccess(OP_LW, 32'h0000_0101, 32'h0, 32'h1122_3344, 0, 40);
        checkOutput("mis_lw_addr",    capAddr, 32'h0000_0100);
        checkOutput("mis_lw_stall",   stallCount, 2);
        checkOutput("mis_lw_ram_out", ramDone, 32'h1122_3344);
        checkOutput("mis_lw_adel",    {31'd0, adelFirst}, 32'd0);
        runAccess(OP_LH, 32'h0000_0103, 32'h0, 32'hBEEF_1234, 0, 40);
        checkOutput("mis_lh_ram_out", ramDone, 32'hFFFF_BEEF);
        runAccess(OP_SW, 32'h0000_0102, 32'hA5A5_0F0F, 32'h0, 0, 40);
        checkOutput("mis_sw_addr",  capAddr, 32'h0000_0100);
        checkOutput("mis_sw_wstrb", {28'd0, capWstrb}, 32'h0000_000F);
        checkOutput("mis_sw_ades",  {31'd0, adesFirst}, 32'd0);
`endif

        // Reset during WAIT abandons the access.
        ex_valid   = 1'b1;
        ex_mem_op  = OP_LW;
        ex_alu_out = 32'h0000_0800;
        bus.dm_ack = 1'b0;
        tick();
        checkOutput("midrst_req_before", {31'd0, bus.dm_req}, 32'd1);
        resetn   = 1'b0;
        ex_valid = 1'b0;
        tick();
        checkOutput("midrst_req",     {31'd0, bus.dm_req}, 32'd0);
        checkOutput("midrst_ram_out", ram_out, 32'd0);
        checkOutput("midrst_state",   {30'd0, dut.state}, {30'd0, ST_IDLE});
        checkOutput("midrst_stall",   {31'd0, mem_stall}, 32'd0);
        resetn    = 1'b1;
        ex_mem_op = OP_NONE;
        tick();

        // Normal access after recovery.
        runAccess(OP_LBU, 32'h0000_0900, 32'h0, 32'h0000_00FE, 0, 40);
        checkOutput("recover_stall",   stallCount, 2);
        checkOutput("recover_ram_out", ramDone, 32'h0000_00FE);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
